data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 28 ++
 rtl/data_mem_responder_if.sv | 22 ++
 rtl/mem_lane_decode.sv | 29 ++
 rtl/data_mem_responder.sv | 106 ++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared size codes, MMIO map and timer constants
package data_mem_responder_pkg;

  typedef enum logic [2:0] {
    SIZE_BYTE   = 3'b000,
    SIZE_HALF   = 3'b001,
    SIZE_WORD   = 3'b010,
    SIZE_BYTE_U = 3'b100,
    SIZE_HALF_U = 3'b101
  } size_e;

  // MMIO window is addr[31:4] == MMIO_BASE; registers selected by addr[3:2]
  localparam logic [27:0] MMIO_BASE      = 28'h1000000;
  localparam logic [1:0]  MMIO_MTIME     = 2'd0;
  localparam logic [1:0]  MMIO_MTIMECMP  = 2'd1;
  localparam logic [1:0]  MMIO_STATUS    = 2'd2;
  localparam logic [31:0] MTIMECMP_RESET = 32'hFFFF_FFFF;

  // Right-justified data mask for an access of the given size; unknown codes act as word
  function automatic logic [31:0] access_mask(input logic [2:0] size_sel);
    case (size_sel)
      SIZE_BYTE, SIZE_BYTE_U: access_mask = 32'h0000_00FF;
      SIZE_HALF, SIZE_HALF_U: access_mask = 32'h0000_FFFF;
      default:                access_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - requester-side data memory bus
interface data_mem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  mem_write;
  logic [2:0]            size_sel;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  misaligned;
  logic                  timer_irq;

  modport master (
    output addr, write_data, mem_write, size_sel,
    input  read_data, misaligned, timer_irq
  );

  modport slave (
    input  addr, write_data, mem_write, size_sel,
    output read_data, misaligned, timer_irq
  );
endinterface

// File: rtl/mem_lane_decode.sv
// rtl/mem_lane_decode.sv - byte-lane enables and alignment check for one access
module mem_lane_decode
  import data_mem_responder_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [2:0] size_sel,
  output logic [3:0] lane_en,
  output logic       misaligned
);

  // Map size and low address bits onto lanes; a misaligned access enables nothing
  always_comb begin
    lane_en    = 4'b0000;
    misaligned = 1'b0;
    case (size_sel)
      SIZE_BYTE, SIZE_BYTE_U: lane_en = 4'b0001 << addr_lo;
      SIZE_HALF, SIZE_HALF_U: begin
        misaligned = addr_lo[0];
        lane_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        misaligned = (addr_lo != 2'b00);
        lane_en    = 4'b1111;
      end
    endcase
    if (misaligned) lane_en = 4'b0000;
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data RAM plus machine timer MMIO behind one request port
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int data_width  = 32
) (
  input logic                clk,
  input logic                rst,
  data_mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [3:0]            lane_en;
  logic                  misaligned;
  logic                  ram_sel;
  logic                  mmio_sel;
  logic                  ram_we;
  logic [IDX_W-1:0]      ram_idx;
  logic [3:0][7:0]       ram [DEPTH_WORDS];
  logic [data_width-1:0] ram_word;
  logic [data_width-1:0] ram_shifted;
  logic [data_width-1:0] wdata_lanes;
  logic [data_width-1:0] read_mux;
  logic [data_width-1:0] mtime;
  logic [data_width-1:0] mtimecmp;
  logic                  pending;
  logic                  mmio_wr;
  logic                  cmp_wr;
  logic                  status_w1c;

  mem_lane_decode u_lane_decode (
    .addr_lo    (bus.addr[1:0]),
    .size_sel   (bus.size_sel),
    .lane_en    (lane_en),
    .misaligned (misaligned)
  );

  assign ram_sel     = (bus.addr[31:28] == 4'h0);
  assign mmio_sel    = (bus.addr[31:4] == MMIO_BASE);
  assign ram_idx     = bus.addr[IDX_W+1:2];
  assign ram_word    = ram[ram_idx];
  assign ram_shifted = ram_word >> {bus.addr[1:0], 3'b000};
  // lane_en is already zero for misaligned accesses; a store overlapping reset is dropped
  assign ram_we      = bus.mem_write & ram_sel & ~rst;

  assign mmio_wr    = bus.mem_write && mmio_sel && !misaligned && (bus.size_sel == SIZE_WORD);
  assign cmp_wr     = mmio_wr && (bus.addr[3:2] == MMIO_MTIMECMP);
  assign status_w1c = mmio_wr && (bus.addr[3:2] == MMIO_STATUS) && bus.write_data[0];

  // Replicate store data so each lane sees its own slice of the value
  always_comb begin
    wdata_lanes = bus.write_data;
    case (bus.size_sel)
      SIZE_BYTE, SIZE_BYTE_U: wdata_lanes = {4{bus.write_data[7:0]}};
      SIZE_HALF, SIZE_HALF_U: wdata_lanes = {2{bus.write_data[15:0]}};
      default:                wdata_lanes = bus.write_data;
    endcase
  end

  // Combinational read: RAM data is right-justified and masked to the access size, MMIO returns the full register
  always_comb begin
    read_mux = '0;
    if (!misaligned) begin
      if (ram_sel) begin
        read_mux = ram_shifted & access_mask(bus.size_sel);
      end else if (mmio_sel) begin
        case (bus.addr[3:2])
          MMIO_MTIME:    read_mux = mtime;
          MMIO_MTIMECMP: read_mux = mtimecmp;
          MMIO_STATUS:   read_mux = {{(data_width-1){1'b0}}, pending};
          default:       read_mux = '0;
        endcase
      end
    end
  end

  // Byte-lane RAM store; left unreset so it infers as block RAM
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i[1:0]]) ram[ram_idx][i[1:0]] <= wdata_lanes[8*i +: 8];
      end
    end
  end

  // Free-running timer; a match sets pending and beats a simultaneous W1C
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RESET;
      pending  <= 1'b0;
    end else begin
      mtime <= mtime + 32'd1;
      if (cmp_wr) mtimecmp <= bus.write_data;
      if (mtime == mtimecmp) pending <= 1'b1;
      else if (status_w1c)   pending <= 1'b0;
    end
  end

  assign bus.read_data  = read_mux;
  assign bus.misaligned = misaligned;
  assign bus.timer_irq  = pending;

endmodule
